unidad_control: RTL and testbench

Microprogrammed control unit that sits directly upstream of the 4-bit processing unit. It fetches 18-bit microinstructions from a synchronous program ROM, drives the processing unit's 16-bit control word, and evaluates the processing unit's registered status flags for conditional branches. It runs a fixed FETCH/DECODE/EXEC sequence per instruction, ending in HALT.

---
 rtl/unidad_control.sv | 100 ++++++++++
 tb/tb_unidad_control.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_control.sv
// Microprogrammed control unit: FETCH/DECODE/EXEC sequencer driving the 4-bit
// processing unit's control word from an 18-bit synchronous microprogram ROM.
module unidad_control #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] rom_addr,
  input  logic [17:0]     rom_data,
  input  logic [3:0]      state_bits,
  output logic [15:0]     ctrl_word,
  output logic            busy,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT
  } state_e;

  localparam logic [1:0] CLS_EXEC = 2'b00;
  localparam logic [1:0] CLS_JMP  = 2'b01;
  localparam logic [1:0] CLS_BR   = 2'b10;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [17:0]     ir_q, ir_d;
  logic [15:0]     ctrl_q, ctrl_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target;
  logic            br_taken;
  logic            unused_ir;

  assign pc_inc    = pc_q + 1'b1;
  assign target    = ir_q[PC_W-1:0];
  // Flags are already registered in the processing unit; sample them live in EXEC.
  assign br_taken  = (state_bits[ir_q[5:4]] == ir_q[6]);
  assign unused_ir = ^ir_q[15:7];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ctrl_d   = ctrl_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = rom_data;
        ctrl_d  = (rom_data[17:16] == CLS_EXEC) ? rom_data[15:0] : 16'h0000;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        ctrl_d  = 16'h0000;
        state_d = S_FETCH;
        case (ir_q[17:16])
          CLS_EXEC: pc_d = pc_inc;
          CLS_JMP:  pc_d = target;
          CLS_BR:   pc_d = br_taken ? target : pc_inc;
          default:  state_d = S_HALT;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      ctrl_q   <= 16'h0000;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ctrl_q   <= ctrl_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign rom_addr  = pc_q;
  assign ctrl_word = ctrl_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_unidad_control.sv
// Scoreboard bench for unidad_control: driver pushes expected fetch address,
// control word and halt flag per instruction; a negedge monitor pops/compares.
module tb_unidad_control;

  localparam int PC_W = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [PC_W-1:0] rom_addr;
  logic [17:0]     rom_data = '0;
  logic [3:0]      state_bits;
  logic [15:0]     ctrl_word;
  logic            busy;
  logic            halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [PC_W-1:0] addr;
    logic [15:0]     ctrl;
    logic            halt;
  } exp_t;

  exp_t exp_q[$];

  logic [17:0] rom [16];
  logic [3:0]  sb_static;
  logic [3:0]  sb_pu;
  logic        use_pu;
  logic        pu_clr;

  always #5 clk = ~clk;

  unidad_control #(.PC_W(PC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .state_bits(state_bits),
    .ctrl_word (ctrl_word),
    .busy      (busy),
    .halted    (halted)
  );

  // Synchronous ROM and a tiny processing-unit flag register (loads ctrl[3:0] when bit 9 set)
  always @(posedge clk) rom_data <= rom[rom_addr];
  always @(posedge clk) begin
    if (pu_clr) sb_pu <= 4'h0;
    else if (ctrl_word[9]) sb_pu <= ctrl_word[3:0];
  end
  assign state_bits = use_pu ? sb_pu : sb_static;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [PC_W-1:0] a, input logic [15:0] c, input logic h);
    exp_t e;
    e.addr = a; e.ctrl = c; e.halt = h;
    exp_q.push_back(e);
  endtask

  // Monitor: FETCH is the first busy cycle, every instruction lasts three cycles
  int   phase = 0;
  bit   after_exec = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      phase = 0;
      after_exec = 0;
    end else begin
      if (after_exec) begin
        chk("halted_after_exec", {31'b0, halted}, {31'b0, cur.halt});
        after_exec = 0;
      end
      if (busy) begin
        if (phase == 0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fetch: got addr %0h expected no fetch", rom_addr);
            cur.addr = rom_addr; cur.ctrl = 16'h0; cur.halt = 1'b0;
          end else begin
            cur = exp_q.pop_front();
            chk("fetch_addr", {28'b0, rom_addr}, {28'b0, cur.addr});
          end
        end
        chk("ctrl_word", {16'b0, ctrl_word}, (phase == 2) ? {16'b0, cur.ctrl} : 32'h0);
        if (phase == 2) after_exec = 1;
        phase = (phase == 2) ? 0 : phase + 1;
      end else begin
        phase = 0;
      end
    end
  end

  task automatic pulse_start(input int n);
    @(posedge clk); #1 start = 1'b1;
    repeat (n) @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_halt(input int max_cyc);
    bit seen = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (halted) begin seen = 1; break; end
    end
    chk("halt_reached", {31'b0, seen}, 32'h1);
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 32'h0);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 18'h30000;
  endtask

  task automatic load_prog_a();
    clear_rom();
    rom[0] = {2'b00, 16'h1A40};
    rom[1] = {2'b00, 16'h0230};
    rom[2] = 18'h30000;
  endtask

  task automatic push_prog_a();
    push(4'd0, 16'h1A40, 1'b0);
    push(4'd1, 16'h0230, 1'b0);
    push(4'd2, 16'h0000, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; use_pu = 1'b0; pu_clr = 1'b1; sb_static = 4'h0;
    clear_rom();
    #12;
    chk("rst_ctrl", {16'b0, ctrl_word}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_addr", {28'b0, rom_addr}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_busy", {31'b0, busy}, 32'h0);
    chk("idle_halted", {31'b0, halted}, 32'h0);
    chk("idle_addr", {28'b0, rom_addr}, 32'h0);

    // Straight-line program
    load_prog_a();
    push_prog_a();
    pulse_start(1);
    wait_halt(40);

    // Restart from HALT: FETCH of 0 with busy the next clk
    push_prog_a();
    pulse_start(1);
    #2;
    chk("halt_restart_busy", {31'b0, busy}, 32'h1);
    chk("halt_restart_addr", {28'b0, rom_addr}, 32'h0);
    wait_halt(40);

    // start held while busy must not restart
    push_prog_a();
    pulse_start(6);
    wait_halt(40);

    // Branch taken / not taken on state_bits[2] == 1
    clear_rom();
    rom[0] = {2'b00, 16'h0001};
    rom[1] = {2'b00, 16'h0002};
    rom[2] = {2'b00, 16'h0003};
    rom[3] = 18'h20069;
    sb_static = 4'b0100;
    push(4'd0, 16'h0001, 1'b0); push(4'd1, 16'h0002, 1'b0); push(4'd2, 16'h0003, 1'b0);
    push(4'd3, 16'h0000, 1'b0); push(4'd9, 16'h0000, 1'b1);
    pulse_start(1);
    wait_halt(60);
    sb_static = 4'b0000;
    push(4'd0, 16'h0001, 1'b0); push(4'd1, 16'h0002, 1'b0); push(4'd2, 16'h0003, 1'b0);
    push(4'd3, 16'h0000, 1'b0); push(4'd4, 16'h0000, 1'b1);
    pulse_start(1);
    wait_halt(60);

    // Wrap 15->0 and JMP, with BR on flags produced by the preceding EXEC
    clear_rom();
    rom[0]  = 18'h2003E;
    rom[14] = {2'b00, 16'h0200};
    rom[15] = {2'b00, 16'h0208};
    rom[1]  = 18'h10007;
    use_pu = 1'b1; pu_clr = 1'b0;
    push(4'd0, 16'h0000, 1'b0); push(4'd14, 16'h0200, 1'b0); push(4'd15, 16'h0208, 1'b0);
    push(4'd0, 16'h0000, 1'b0); push(4'd1, 16'h0000, 1'b0); push(4'd7, 16'h0000, 1'b1);
    pulse_start(1);
    wait_halt(60);
    use_pu = 1'b0;

    // Reset during DECODE of an EXEC instruction
    load_prog_a();
    push_prog_a();
    pulse_start(1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {16'b0, ctrl_word}, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_addr", {28'b0, rom_addr}, 32'h0);
    @(posedge clk); #1;
    chk("midrst_ctrl_hold", {16'b0, ctrl_word}, 32'h0);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_idle", {31'b0, busy}, 32'h0);
    push_prog_a();
    pulse_start(1);
    wait_halt(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
